// File: rtl/md_issue.sv
// EX-stage issue/interlock controller for the HI/LO multiply/divide unit.
// Registers unit inputs on issue, models op latency and stalls HI/LO users.
module md_issue #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [3:0]  md_op,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic        mf_hi,
    input  logic        mf_lo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        md_busy,
    output logic        md_start,
    output logic [3:0]  md_op_q,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_whi,
    output logic        md_wlo,
    output logic        busy,
    output logic        stall
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state, state_next;
    logic [5:0] cnt, cnt_next;

    logic is_md, is_mul, hilo_req, can_act, issue, mt_write;

    assign is_md    = (md_op >= 4'd1) && (md_op <= 4'd4);
    assign is_mul   = (md_op == 4'd1) || (md_op == 4'd2);
    assign hilo_req = ex_valid & (is_md | mt_hi | mt_lo | mf_hi | mf_lo);
    assign can_act  = (state == IDLE) & ~md_busy & ex_valid & ~flush;
    // A real mult/div in the same slot wins over mthi/mtlo.
    assign issue    = can_act & is_md;
    assign mt_write = can_act & ~is_md & (mt_hi | mt_lo);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = BUSY;
                    cnt_next   = is_mul ? MUL_LOAD : DIV_LOAD;
                end
            end
            BUSY: begin
                if (cnt != 6'd0)
                    cnt_next = cnt - 6'd1;
                else if (!md_busy)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == BUSY);
        stall = hilo_req & (busy | md_start | md_busy);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_start <= 1'b0;
            md_whi   <= 1'b0;
            md_wlo   <= 1'b0;
            md_op_q  <= '0;
            md_a     <= '0;
            md_b     <= '0;
        end else begin
            md_start <= issue;
            md_whi   <= mt_write & mt_hi;
            md_wlo   <= mt_write & mt_lo;
            if (issue) begin
                md_op_q <= md_op;
                md_a    <= rs_val;
                md_b    <= rt_val;
            end else if (mt_write) begin
                md_a    <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue: a per-cycle vector table plus hand-written
// multi-cycle sequences for latency, back-to-back issue, unit hold and reset.
module tb_md_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, mt_hi, mt_lo, mf_hi, mf_lo, flush, md_busy;
    logic [3:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        md_start, md_whi, md_wlo, busy, stall;
    logic [3:0]  md_op_q;
    logic [31:0] md_a, md_b;

    int checks = 0;
    int errors = 0;

    md_issue #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .md_op(md_op),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .mf_hi(mf_hi), .mf_lo(mf_lo),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .md_busy(md_busy),
        .md_start(md_start), .md_op_q(md_op_q), .md_a(md_a), .md_b(md_b),
        .md_whi(md_whi), .md_wlo(md_wlo), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    // Inputs applied during a cycle and the outputs expected in that same cycle.
    typedef struct packed {
        logic        rst;
        logic        v;
        logic [3:0]  op;
        logic        mth, mtl, mfh, mfl, fl, mb;
        logic [31:0] rs, rt;
        logic        e_start;
        logic [3:0]  e_opq;
        logic [31:0] e_a, e_b;
        logic        e_whi, e_wlo, e_busy, e_stall;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic mth, input logic mtl,
                         input logic mfh, input logic mfl, input logic fl, input logic mb,
                         input logic [31:0] rs, input logic [31:0] rt);
        ex_valid = v; md_op = op; mt_hi = mth; mt_lo = mtl; mf_hi = mfh; mf_lo = mfl;
        flush = fl; md_busy = mb; rs_val = rs; rt_val = rt;
    endtask

    task automatic idle();
        drive(0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        //          rst v op   mth mtl mfh mfl fl mb rs            rt       | st opq  a             b        whi wlo bsy stl
        vecs[0]  = '{0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 4'd0, 32'h0,        32'h0,    0, 0, 0, 0};
        vecs[1]  = '{1, 1, 4'd1, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'h3,    0, 4'd0, 32'h0,        32'h0,    0, 0, 0, 0};
        vecs[2]  = '{1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    1, 4'd1, 32'hFFFFFFFE, 32'h3,    0, 0, 1, 0};
        vecs[3]  = '{1, 1, 4'd0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,    0, 4'd1, 32'hFFFFFFFE, 32'h3,    0, 0, 1, 1};
        vecs[4]  = '{1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 4'd1, 32'hFFFFFFFE, 32'h3,    0, 0, 1, 0};
        vecs[5]  = '{1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 4'd1, 32'hFFFFFFFE, 32'h3,    0, 0, 1, 0};
        vecs[6]  = '{1, 1, 4'd2, 0, 0, 0, 0, 0, 0, 32'h11,       32'h22,   0, 4'd1, 32'hFFFFFFFE, 32'h3,    0, 0, 1, 1};
        vecs[7]  = '{1, 1, 4'd0, 1, 0, 0, 0, 0, 0, 32'h12345678, 32'h0,    0, 4'd1, 32'hFFFFFFFE, 32'h3,    0, 0, 0, 0};
        vecs[8]  = '{1, 1, 4'd0, 1, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0,    0, 4'd1, 32'h12345678, 32'h3,    1, 0, 0, 0};
        vecs[9]  = '{1, 1, 4'd0, 1, 1, 0, 0, 0, 0, 32'hAA,       32'h0,    0, 4'd1, 32'h12345678, 32'h3,    0, 0, 0, 0};
        vecs[10] = '{1, 1, 4'd7, 0, 0, 0, 1, 0, 0, 32'h5,        32'h0,    0, 4'd1, 32'hAA,       32'h3,    1, 1, 0, 0};
        vecs[11] = '{1, 1, 4'd3, 0, 0, 0, 0, 1, 0, 32'h9,        32'h9,    0, 4'd1, 32'hAA,       32'h3,    0, 0, 0, 0};
        vecs[12] = '{1, 1, 4'd0, 0, 1, 0, 0, 0, 1, 32'h77,       32'h0,    0, 4'd1, 32'hAA,       32'h3,    0, 0, 0, 1};
        vecs[13] = '{1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    0, 4'd1, 32'hAA,       32'h3,    0, 0, 0, 0};

        reset = 1'b0;
        idle();
        next_cycle();
        next_cycle();

        for (int i = 0; i < 14; i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].v, vecs[i].op, vecs[i].mth, vecs[i].mtl, vecs[i].mfh, vecs[i].mfl,
                  vecs[i].fl, vecs[i].mb, vecs[i].rs, vecs[i].rt);
            @(negedge clk);
            check($sformatf("v%0d md_start", i), 32'(md_start), 32'(vecs[i].e_start));
            check($sformatf("v%0d md_op_q", i),  32'(md_op_q),  32'(vecs[i].e_opq));
            check($sformatf("v%0d md_a", i),     md_a,          vecs[i].e_a);
            check($sformatf("v%0d md_b", i),     md_b,          vecs[i].e_b);
            check($sformatf("v%0d md_whi", i),   32'(md_whi),   32'(vecs[i].e_whi));
            check($sformatf("v%0d md_wlo", i),   32'(md_wlo),   32'(vecs[i].e_wlo));
            check($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].e_busy));
            check($sformatf("v%0d stall", i),    32'(stall),    32'(vecs[i].e_stall));
            next_cycle();
        end

        // divu by zero with a simultaneous mthi, then a dependent mflo held in EX.
        drive(1, 4'd4, 1, 0, 0, 0, 0, 0, 32'h64, 32'h0);
        @(negedge clk);
        check("divu T stall", 32'(stall), 32'd0);
        next_cycle();
        for (int k = 1; k <= 11; k++) begin
            drive(1, 4'd0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
            @(negedge clk);
            if (k == 1) begin
                check("divu start", 32'(md_start), 32'd1);
                check("divu no whi", 32'(md_whi), 32'd0);
                check("divu op_q", 32'(md_op_q), 32'd4);
                check("divu b", md_b, 32'h0);
            end
            check($sformatf("divu stall k%0d", k), 32'(stall), 32'(k <= 10));
            next_cycle();
        end
        idle();

        // mult then a div arriving right behind it.
        drive(1, 4'd1, 0, 0, 0, 0, 0, 0, 32'h2, 32'h3);
        next_cycle();
        for (int k = 1; k <= 17; k++) begin
            if (k <= 6) drive(1, 4'd3, 0, 0, 0, 0, 0, 0, 32'h10, 32'h2);
            else        idle();
            @(negedge clk);
            if (k <= 6) check($sformatf("b2b stall k%0d", k), 32'(stall), 32'(k <= 5));
            if (k == 6) check("b2b no early start", 32'(md_start), 32'd0);
            if (k == 7) begin
                check("b2b div start", 32'(md_start), 32'd1);
                check("b2b div op_q", 32'(md_op_q), 32'd3);
                check("b2b div a", md_a, 32'h10);
            end
            if (k >= 16) check($sformatf("b2b busy k%0d", k), 32'(busy), 32'(k == 16));
            next_cycle();
        end

        // mult whose unit keeps md_busy high past the modelled latency.
        drive(1, 4'd1, 0, 0, 0, 0, 0, 0, 32'h1, 32'h1);
        next_cycle();
        for (int k = 1; k <= 9; k++) begin
            drive(1, 4'd0, 0, 0, 1, 0, 0, logic'(k <= 7), 32'h0, 32'h0);
            @(negedge clk);
            check($sformatf("hold busy k%0d", k), 32'(busy), 32'(k <= 8));
            check($sformatf("hold stall k%0d", k), 32'(stall), 32'(k <= 8));
            next_cycle();
        end
        idle();

        // Reset asserted for three cycles in the middle of a divide.
        drive(1, 4'd3, 0, 0, 0, 0, 0, 0, 32'h55, 32'h66);
        next_cycle();
        for (int k = 1; k <= 6; k++) begin
            if (k >= 4) begin
                reset = 1'b0;
                drive(1, 4'd1, 0, 0, 0, 0, 0, 0, 32'h99, 32'h99);
            end else begin
                idle();
            end
            next_cycle();
        end
        reset = 1'b1;
        drive(1, 4'd0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst md_start", 32'(md_start), 32'd0);
        check("rst md_op_q", 32'(md_op_q), 32'd0);
        check("rst md_a", md_a, 32'h0);
        check("rst md_b", md_b, 32'h0);
        check("rst md_whi", 32'(md_whi), 32'd0);
        check("rst md_wlo", 32'(md_wlo), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst stall", 32'(stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_issue.md
Name: md_issue

Overview:
- EX-stage issue and interlock controller sitting directly upstream of the HI/LO multiply/divide unit.
- Decodes mult/multu/div/divu/mthi/mtlo requests arriving in EX and drives the unit's start, operand, MULOp and whi/wlo inputs from registers.
- Models the operation latency and stalls the pipeline for any HI/LO-touching instruction until the result is valid.

Parameters:
MUL_CYCLES, 5, busy cycles for mult/multu (1..63)
DIV_CYCLES, 10, busy cycles for div/divu (1..63)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-low; clears all state when 0 at a rising clk edge
ex_valid  input  1  EX holds a valid, non-bubble instruction
md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu; 5..15 treated as none
mt_hi  input  1  EX instruction is mthi
mt_lo  input  1  EX instruction is mtlo
mf_hi  input  1  EX instruction is mfhi
mf_lo  input  1  EX instruction is mflo
rs_val  input  32  forwarded rs operand
rt_val  input  32  forwarded rt operand
flush  input  1  EX instruction is being squashed this cycle
md_busy  input  1  busy flag returned by the multiply/divide unit
md_start  output  1  one-cycle start pulse to the unit
md_op_q  output  4  registered MULOp to the unit
md_a  output  32  registered A operand (rs, or mt source)
md_b  output  32  registered B operand (rt)
md_whi  output  1  one-cycle HI write pulse (mthi)
md_wlo  output  1  one-cycle LO write pulse (mtlo)
busy  output  1  1 while state is BUSY
stall  output  1  freeze IF/ID/EX this cycle (combinational)

Behaviour:
- Reset (reset==0 at edge): state IDLE, cnt=0; md_start, md_whi, md_wlo, busy =0; md_op_q=0; md_a, md_b =0. Reset mid-operation aborts immediately; cnt discarded.
- hilo_req = ex_valid & (md_op in 1..4 | mt_hi | mt_lo | mf_hi | mf_lo).
- stall = hilo_req & (state==BUSY | md_start | md_busy). Combinational; never depends on flush.
- Issue (cycle T): state IDLE, md_busy==0, ex_valid, md_op in 1..4, !flush. At edge T: md_a<=rs_val, md_b<=rt_val, md_op_q<=md_op, md_start<=1, state<=BUSY, cnt<=(mult/multu ? MUL_CYCLES : DIV_CYCLES)-1.
- md_start high only in cycle T+1; cleared at next edge unconditionally.
- BUSY: each edge, if cnt!=0 then cnt<=cnt-1; if cnt==0 and md_busy==0 then state<=IDLE; if cnt==0 and md_busy==1, stay BUSY until md_busy drops.
- Net: BUSY for cycles T+1..T+N; dependent instruction held in EX from T+1 proceeds in cycle T+N+1.
- mthi/mtlo (cycle T): IDLE, md_busy==0, ex_valid, !flush, md_op none. At edge: md_a<=rs_val, md_whi<=mt_hi (or md_wlo<=mt_lo), one-cycle pulse; state stays IDLE. mt_hi and mt_lo both set: both pulses.
- mfhi/mflo while IDLE and md_busy==0: no action, no stall; the datapath reads HI/LO directly.
- Priority: md_op in 1..4 overrides mt_hi/mt_lo in the same cycle; mt ignored.
- Flush with request: no issue, no pulse; a flush never cancels an operation already in BUSY.
- Divide by zero: issued normally; full DIV_CYCLES latency.
- md_op_q, md_a, md_b hold their value between issues.
- md_start, md_whi and md_wlo are mutually exclusive except md_whi+md_wlo.

Test Plan:
- Reset held 0 for 3 cycles mid-divide (cnt=6) -> next cycle all outputs 0, busy=0, stall=0 with hilo_req=1.
- mult rs=0xFFFFFFFE rt=3 at T -> md_start=1 only at T+1, md_op_q=1, md_a=0xFFFFFFFE, md_b=3, busy high T+1..T+5, low at T+6.
- divu at T, mflo in EX from T+1 -> stall=1 for exactly cycles T+1..T+10, stall=0 at T+11.
- Back-to-back mult at T, div at T+1 -> div stalled T+1..T+5, issues at T+6, md_start at T+7, md_op_q=3.
- mthi rs=0x12345678 while IDLE -> md_whi=1 one cycle, md_a=0x12345678, md_start=0, stall=0; same with flush=1 -> no pulse.
- mult issued, md_busy held 1 until T+8 -> busy stays 1 through T+8, IDLE at T+9; dependent mfhi released at T+9.
